// File: rtl/dezigzag_reorder_if.sv
// axi4_stream_if: minimal AXI4-Stream bundle (tdata/tvalid/tready/tlast) with master/slave views.
interface axi4_stream_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dezigzag_reorder.sv
// dezigzag_reorder: zigzag-ordered coefficient blocks in, row-major blocks out, via ping-pong block RAMs.
module dezigzag_reorder #(
   parameter int COEF_WIDTH  = 12,
   parameter int MAT_SIZE    = 8,
   parameter int TDATA_WIDTH = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   axi4_stream_if.slave video_i,
   axi4_stream_if.master video_o,
   output logic         protocol_err_o
);
   localparam int N2 = MAT_SIZE * MAT_SIZE;
   localparam int AW = $clog2(N2);
   localparam int IW = $clog2(MAT_SIZE);
   localparam logic [IW-1:0] EDGE = IW'(MAT_SIZE - 1);
   localparam logic [AW-1:0] LAST = AW'(N2 - 1);

   logic [COEF_WIDTH-1:0] mem [2][N2];
   logic [IW-1:0]         row, col, row_n, col_n;
   logic                  up, up_n;
   logic [AW-1:0]         cnt, rd_addr, wr_addr;
   logic [1:0]            full;
   logic                  wr_bank, rd_bank;
   logic [COEF_WIDTH:0]   fifo [2];
   logic                  wp, rp;
   logic [1:0]            fcnt;
   logic                  in_fire, blk_end, pop, issue;

   assign video_i.tready = !full[wr_bank] && !rst_i;
   assign in_fire        = video_i.tvalid && video_i.tready;
   assign blk_end        = cnt == LAST;
   assign wr_addr        = AW'(row * MAT_SIZE + col);
   assign pop            = video_o.tvalid && video_o.tready;
   // The RAM read lands directly in a FIFO slot, so a slot freed this cycle can be refilled.
   assign issue          = full[rd_bank] && (fcnt != 2'd2 || pop);
   assign video_o.tvalid = fcnt != 2'd0;
   assign video_o.tdata  = TDATA_WIDTH'(fifo[rp][COEF_WIDTH-1:0]);
   assign video_o.tlast  = fifo[rp][COEF_WIDTH];

   always_comb begin
      row_n = row;
      col_n = col;
      up_n  = up;
      if (up) begin
         if (col == EDGE) begin
            row_n = row + 1'b1;
            up_n  = 1'b0;
         end else if (row == '0) begin
            col_n = col + 1'b1;
            up_n  = 1'b0;
         end else begin
            row_n = row - 1'b1;
            col_n = col + 1'b1;
         end
      end else begin
         if (row == EDGE) begin
            col_n = col + 1'b1;
            up_n  = 1'b1;
         end else if (col == '0) begin
            row_n = row + 1'b1;
            up_n  = 1'b1;
         end else begin
            row_n = row + 1'b1;
            col_n = col - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) if (in_fire) mem[wr_bank][wr_addr] <= video_i.tdata[COEF_WIDTH-1:0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row            <= '0;
         col            <= '0;
         up             <= 1'b1;
         cnt            <= '0;
         full           <= '0;
         wr_bank        <= 1'b0;
         rd_bank        <= 1'b0;
         rd_addr        <= '0;
         wp             <= 1'b0;
         rp             <= 1'b0;
         fcnt           <= '0;
         fifo[0]        <= '0;
         fifo[1]        <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         if (in_fire) begin
            if (video_i.tlast != blk_end) protocol_err_o <= 1'b1;
            row <= blk_end ? '0 : row_n;
            col <= blk_end ? '0 : col_n;
            up  <= blk_end | up_n;
            cnt <= blk_end ? '0 : cnt + 1'b1;
            if (blk_end) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= !wr_bank;
            end
         end
         // Clear is written after set so it wins if both ever hit the same flag.
         if (issue) begin
            fifo[wp] <= {rd_addr == LAST, mem[rd_bank][rd_addr]};
            wp       <= !wp;
            rd_addr  <= (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
            if (rd_addr == LAST) begin
               full[rd_bank] <= 1'b0;
               rd_bank       <= !rd_bank;
            end
         end
         if (pop) rp <= !rp;
         fcnt <= fcnt + {1'b0, issue} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_dezigzag_reorder.sv
// tb_dezigzag_reorder: random blocks sent in zigzag order, checked against a row-major scoreboard.
module tb_dezigzag_reorder;
   localparam int CW = 12;
   localparam int N  = 8;
   localparam int N2 = N * N;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err;
   always #5 clk = ~clk;

   axi4_stream_if #(.DATA_WIDTH(DW)) vi ();
   axi4_stream_if #(.DATA_WIDTH(DW)) vo ();

   dezigzag_reorder #(.COEF_WIDTH(CW), .MAT_SIZE(N), .TDATA_WIDTH(DW)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .video_i(vi),
      .video_o(vo),
      .protocol_err_o(err)
   );

   int checks = 0;
   int failures = 0;
   int zz[N2];
   logic [DW:0] exp_q[$];
   logic [DW:0] mon_e;
   int cyc = 0;
   int mode = 0;
   int phase = 0;
   int in_total = 0;
   int out_total = 0;
   int stalls = 0;
   int last_in_cyc = 0;
   int first_valid_cyc = -1;
   int hs_first = -1;
   int hs_last = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   initial forever begin
      @(posedge clk);
      #1 vo.tready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 99) >= 30) : 1'b0;
   end

   always @(negedge clk) begin
      if (!rst && vi.tvalid && !vi.tready) begin
         stalls++;
         if (phase == 3) check("bp_stall_early", 32'(in_total - out_total > N2), 1);
      end
      if (!rst && vo.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!rst && vo.tvalid && vo.tready) begin
         if (exp_q.size() == 0) check("unexpected_out", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            check("out_data", 32'(vo.tdata), 32'(mon_e[DW-1:0]));
            check("out_last", 32'(vo.tlast), 32'(mon_e[DW]));
         end
         out_total++;
         if (hs_first < 0) hs_first = cyc;
         hs_last = cyc;
      end
   end

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic send(input logic [CW-1:0] d, input logic l);
      int t = 0;
      vi.tvalid = 1'b1;
      vi.tdata  = DW'(d);
      vi.tlast  = l;
      forever begin
         @(negedge clk);
         if (vi.tready) begin
            last_in_cyc = cyc;
            in_total++;
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
         t++;
         if (t > 400) begin
            check("in_timeout", 0, 1);
            finish_run();
            $fatal(1, "input handshake timed out");
         end
      end
   endtask

   // err_at >= 0: flag must track position; -1: flag must stay clear; < -1: not examined.
   task automatic send_block(input int tl_pos, input bit ramp, input int err_at);
      logic [CW-1:0] v[N2];
      logic [DW:0] e;
      for (int i = 0; i < N2; i++) begin
         v[i] = ramp ? CW'(i) : CW'($urandom);
         e = '0;
         e[CW-1:0] = v[i];
         e[DW] = (i == N2 - 1);
         exp_q.push_back(e);
      end
      for (int k = 0; k < N2; k++) begin
         send(v[zz[k]], k == tl_pos);
         if (err_at >= 0) check("perr_track", 32'(err), 32'(k >= err_at));
      end
      if (err_at == -1) check("perr_clear", 32'(err), 0);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input int m);
      mode = m;
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      #500000;
      check("global_timeout", 0, 1);
      finish_run();
      $fatal(1, "global timeout");
   end

   initial begin
      int k = 0;
      bit seen;
      int bf_base;
      for (int s = 0; s < 2 * N - 1; s++) begin
         for (int j = 0; j < N; j++) begin
            int r;
            int c;
            r = (s % 2 == 0) ? s - j : j;
            c = s - r;
            if (r >= 0 && r < N && c >= 0 && c < N) begin
               zz[k] = r * N + c;
               k++;
            end
         end
      end
      vi.tvalid = 1'b0;
      vi.tdata  = '0;
      vi.tlast  = 1'b0;
      vo.tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(vi.tready), 0);
      check("rst_out_valid", 32'(vo.tvalid), 0);
      check("rst_out_last", 32'(vo.tlast), 0);
      check("rst_out_data", 32'(vo.tdata), 0);
      check("rst_perr", 32'(err), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rel_in_ready", 32'(vi.tready), 1);
      @(posedge clk);
      #1;

      first_valid_cyc = -1;
      send_block(N2 - 1, 1'b1, -1);
      vi.tvalid = 1'b0;
      drain();
      check("ramp_latency", 32'(first_valid_cyc - last_in_cyc), 2);

      stalls = 0;
      hs_first = -1;
      for (int b = 0; b < 4; b++) send_block(N2 - 1, 1'b0, -1);
      vi.tvalid = 1'b0;
      drain();
      check("stream_stalls", stalls, 0);
      check("stream_gapless", 32'(hs_last - hs_first + 1), 4 * N2);

      set_mode(1);
      phase = 3;
      for (int b = 0; b < 3; b++) send_block(N2 - 1, 1'b0, -1);
      vi.tvalid = 1'b0;
      drain();
      phase = 0;

      set_mode(2);
      stalls = 0;
      send_block(N2 - 1, 1'b0, -1);
      send_block(N2 - 1, 1'b0, -1);
      vi.tvalid = 1'b0;
      check("bf_no_early_stall", stalls, 0);
      @(negedge clk);
      check("bf_ready_low", 32'(vi.tready), 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("bf_ready_held", 32'(vi.tready), 0);
      bf_base = out_total;
      mode = 0;
      seen = 1'b0;
      for (int t = 0; t < 300 && !seen; t++) begin
         @(posedge clk);
         #2;
         if (vi.tready) begin
            seen = 1'b1;
            check("bf_ready_at", 32'(out_total - bf_base), N2 - 2);
         end
      end
      if (!seen) check("bf_ready_timeout", 0, 1);
      drain();

      check("perr_before", 32'(err), 0);
      send_block(40, 1'b0, 40);
      vi.tvalid = 1'b0;
      drain();
      check("perr_sticky", 32'(err), 1);

      set_mode(2);
      send_block(N2 - 1, 1'b0, -2);
      for (int i = 0; i < 20; i++) send(CW'($urandom), 1'b0);
      vi.tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_out_valid", 32'(vo.tvalid), 0);
      check("mid_rst_out_last", 32'(vo.tlast), 0);
      check("mid_rst_out_data", 32'(vo.tdata), 0);
      check("mid_rst_in_ready", 32'(vi.tready), 0);
      check("mid_rst_perr", 32'(err), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      set_mode(0);
      send_block(N2 - 1, 1'b0, -1);
      vi.tvalid = 1'b0;
      drain();
      check("final_queue", exp_q.size(), 0);
      finish_run();
      $finish;
   end
endmodule
